// File: rtl/time_cnt_12.sv
// 12-hour BCD time-of-day counter with a one-second divider and set-mode buttons.
// Define TIME_CNT_PM_FLAG_EN to add the pm output and its register.
module time_cnt_12 #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       set_mode,
    input  logic       btn_hour,
    input  logic       btn_min,
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] min_ones,
    output logic [3:0] min_tens,
    output logic [3:0] hour_bin,
    output logic       hour_tens,
    output logic       sec_pulse
`ifdef TIME_CNT_PM_FLAG_EN
    ,
    output logic       pm
`endif
);

    localparam int               DIV_W    = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

    typedef struct packed {
        logic [3:0] hour;
        logic [3:0] min_tens;
        logic [3:0] min_ones;
        logic [3:0] sec_tens;
        logic [3:0] sec_ones;
    } clock_t;

    // Returns {carry, tens, ones} for a 00..59 BCD pair advanced by one.
    function automatic logic [8:0] bcd60_inc(input logic [3:0] tens, input logic [3:0] ones);
        logic [8:0] r;
        if (ones < 4'd9)
            r = {1'b0, tens, ones + 4'd1};
        else if (tens < 4'd5)
            r = {1'b0, tens + 4'd1, 4'd0};
        else
            r = {1'b1, 8'h00};
        return r;
    endfunction

    function automatic logic [3:0] hour_inc(input logic [3:0] h);
        return (h >= 4'd12 || h == 4'd0) ? 4'd1 : h + 4'd1;
    endfunction

    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] div_nxt;
    logic             tick;
    clock_t           cur;
    clock_t           nxt;
    logic [8:0]       sec_inc;
    logic [8:0]       min_inc;
    logic [3:0]       hour_next;

    assign cur       = {hour_bin, min_tens, min_ones, sec_tens, sec_ones};
    assign sec_inc   = bcd60_inc(sec_tens, sec_ones);
    assign min_inc   = bcd60_inc(min_tens, min_ones);
    assign hour_next = hour_inc(hour_bin);

    // NOTE: every signal gets a default before any branch so no path leaves it unassigned and infers a latch.
    always_comb begin
        tick    = 1'b0;
        div_nxt = '0;
        nxt     = cur;
        if (set_mode) begin
            // Setting time: divider and seconds parked at zero, buttons edit directly.
            nxt.sec_tens = 4'd0;
            nxt.sec_ones = 4'd0;
            if (btn_min) begin
                nxt.min_tens = min_inc[7:4];
                nxt.min_ones = min_inc[3:0];
            end
            if (btn_hour)
                nxt.hour = hour_next;
        end else begin
            tick    = (div_cnt == DIV_LAST);
            div_nxt = tick ? '0 : div_cnt + DIV_W'(1);
            if (tick) begin
                nxt.sec_tens = sec_inc[7:4];
                nxt.sec_ones = sec_inc[3:0];
                if (sec_inc[8]) begin
                    nxt.min_tens = min_inc[7:4];
                    nxt.min_ones = min_inc[3:0];
                    if (min_inc[8])
                        nxt.hour = hour_next;
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt   <= '0;
            hour_bin  <= 4'd12;
            hour_tens <= 1'b1;
            min_tens  <= 4'd0;
            min_ones  <= 4'd0;
            sec_tens  <= 4'd0;
            sec_ones  <= 4'd0;
            sec_pulse <= 1'b0;
        end else begin
            div_cnt   <= div_nxt;
            hour_bin  <= nxt.hour;
            hour_tens <= (nxt.hour >= 4'd10);
            min_tens  <= nxt.min_tens;
            min_ones  <= nxt.min_ones;
            sec_tens  <= nxt.sec_tens;
            sec_ones  <= nxt.sec_ones;
            sec_pulse <= tick;
        end
    end

`ifdef TIME_CNT_PM_FLAG_EN
    // Meridiem flips only on 11 -> 12, whether reached by carry or by button.
    always_ff @(posedge clk) begin
        if (rst)
            pm <= 1'b0;
        else if (hour_bin == 4'd11 && nxt.hour == 4'd12)
            pm <= ~pm;
    end
`endif

endmodule

// File: tb/tb_time_cnt_12.sv
// Self-checking bench for time_cnt_12 (TICK_DIV=4) against a seconds-of-day reference model.
// pm checks are active only when TIME_CNT_PM_FLAG_EN is defined.
module tb_time_cnt_12;

    localparam int TICK_DIV = 4;
`ifdef TIME_CNT_PM_FLAG_EN
    localparam bit PM_EN = 1'b1;
`else
    localparam bit PM_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       set_mode = 1'b0;
    logic       btn_hour = 1'b0;
    logic       btn_min = 1'b0;
    logic [3:0] sec_ones, sec_tens, min_ones, min_tens, hour_bin;
    logic       hour_tens, sec_pulse;
`ifdef TIME_CNT_PM_FLAG_EN
    logic       pm;
`endif

    int total = 0;
    int bad   = 0;

    // Reference model: plain hour/minute/second integers plus a run-cycle count.
    int m_h = 12, m_m = 0, m_s = 0, m_pm = 0, m_run = 0;
    bit m_pulse = 1'b0;

    always #5 clk = ~clk;

    time_cnt_12 #(.TICK_DIV(TICK_DIV)) dut (
        .clk       (clk),
        .rst       (rst),
        .set_mode  (set_mode),
        .btn_hour  (btn_hour),
        .btn_min   (btn_min),
        .sec_ones  (sec_ones),
        .sec_tens  (sec_tens),
        .min_ones  (min_ones),
        .min_tens  (min_tens),
        .hour_bin  (hour_bin),
        .hour_tens (hour_tens),
        .sec_pulse (sec_pulse)
`ifdef TIME_CNT_PM_FLAG_EN
        ,
        .pm        (pm)
`endif
    );

    logic [22:0] obs;
`ifdef TIME_CNT_PM_FLAG_EN
    assign obs = {pm, hour_bin, hour_tens, min_tens, min_ones, sec_tens, sec_ones, sec_pulse};
`else
    assign obs = {1'b0, hour_bin, hour_tens, min_tens, min_ones, sec_tens, sec_ones, sec_pulse};
`endif

    function automatic logic [22:0] mk(input int pmv, input int h, input int mm, input int ss, input bit pulse);
        return {PM_EN ? pmv[0] : 1'b0, 4'(h), (h >= 10), 4'(mm / 10), 4'(mm % 10),
                4'(ss / 10), 4'(ss % 10), pulse};
    endfunction

    function automatic logic [22:0] exp_vec();
        return mk(m_pm, m_h, m_m, m_s, m_pulse);
    endfunction

    task automatic model_step(input logic r, input logic sm, input logic bh, input logic bm);
        int t;
        int nh;
        if (r) begin
            m_h = 12; m_m = 0; m_s = 0; m_pm = 0; m_run = 0; m_pulse = 1'b0;
        end else if (sm) begin
            m_run = 0; m_s = 0; m_pulse = 1'b0;
            if (bm) m_m = (m_m + 1) % 60;
            if (bh) begin
                if (m_h == 11) m_pm = 1 - m_pm;
                m_h = (m_h % 12) + 1;
            end
        end else begin
            m_run   = m_run + 1;
            m_pulse = (m_run % TICK_DIV == 0);
            if (m_pulse) begin
                t  = ((m_h % 12) * 3600 + m_m * 60 + m_s + 1) % 43200;
                nh = t / 3600;
                if (nh == 0) nh = 12;
                if (m_h == 11 && nh == 12) m_pm = 1 - m_pm;
                m_h = nh;
                m_m = (t / 60) % 60;
                m_s = t % 60;
            end
        end
    endtask

    task automatic drive(input logic r, input logic sm, input logic bh, input logic bm);
        rst = r; set_mode = sm; btn_hour = bh; btn_min = bm;
        @(posedge clk);
        model_step(r, sm, bh, bm);
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [22:0] e;
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        e = mk(0, 12, 0, 0, 1'b0);
        total++;
        if (obs !== e) begin bad++; $display("FAIL reset_state: got %h want %h", obs, e); end
        drive(1'b1, 1'b1, 1'b1, 1'b1);
        total++;
        if (obs !== e) begin bad++; $display("FAIL reset_overrides_set: got %h want %h", obs, e); end
    endtask

    task automatic test_first_second();
        logic [22:0] e;
        for (int i = 1; i <= TICK_DIV; i++) begin
            drive(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            e = (i < TICK_DIV) ? mk(0, 12, 0, 0, 1'b0) : mk(0, 12, 0, 1, 1'b1);
            total++;
            if (obs !== e) begin bad++; $display("FAIL first_second c%0d: got %h want %h", i, obs, e); end
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        e = mk(0, 12, 0, 1, 1'b0);
        total++;
        if (obs !== e) begin bad++; $display("FAIL pulse_one_cycle: got %h want %h", obs, e); end
    endtask

    task automatic test_set_rollover();
        logic [22:0] e;
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        e = mk(0, 12, 0, 0, 1'b0);
        total++;
        if (obs !== e) begin bad++; $display("FAIL set_clears_seconds: got %h want %h", obs, e); end
        repeat (11) drive(1'b0, 1'b1, 1'b1, 1'b0);
        repeat (59) drive(1'b0, 1'b1, 1'b0, 1'b1);
        e = mk(0, 11, 59, 0, 1'b0);
        total++;
        if (obs !== e) begin bad++; $display("FAIL set_1159: got %h want %h", obs, e); end
        for (int i = 1; i <= 60 * TICK_DIV; i++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b0);
            e = exp_vec();
            total++;
            if (obs !== e) begin bad++; $display("FAIL run_to_noon c%0d: got %h want %h", i, obs, e); end
            if (i == 59 * TICK_DIV) begin
                e = mk(0, 11, 59, 59, 1'b1);
                total++;
                if (obs !== e) begin bad++; $display("FAIL at_115959: got %h want %h", obs, e); end
            end
        end
        e = mk(1, 12, 0, 0, 1'b1);
        total++;
        if (obs !== e) begin bad++; $display("FAIL noon_pm: got %h want %h", obs, e); end
    endtask

    task automatic test_noon_to_one();
        logic [22:0] e;
        repeat (59) drive(1'b0, 1'b1, 1'b0, 1'b1);
        repeat (59 * TICK_DIV) drive(1'b0, 1'b0, 1'b0, 1'b0);
        e = mk(1, 12, 59, 59, 1'b1);
        total++;
        if (obs !== e) begin bad++; $display("FAIL at_125959: got %h want %h", obs, e); end
        repeat (TICK_DIV) drive(1'b0, 1'b0, 1'b0, 1'b0);
        e = mk(1, 1, 0, 0, 1'b1);
        total++;
        if (obs !== e) begin bad++; $display("FAIL one_oclock: got %h want %h", obs, e); end
    endtask

    task automatic test_same_cycle();
        logic [22:0] e;
        repeat (9)  drive(1'b0, 1'b1, 1'b1, 1'b0);
        repeat (59) drive(1'b0, 1'b1, 1'b0, 1'b1);
        e = mk(1, 10, 59, 0, 1'b0);
        total++;
        if (obs !== e) begin bad++; $display("FAIL set_1059: got %h want %h", obs, e); end
        drive(1'b0, 1'b1, 1'b1, 1'b1);
        e = mk(1, 11, 0, 0, 1'b0);
        total++;
        if (obs !== e) begin bad++; $display("FAIL both_buttons: got %h want %h", obs, e); end
        drive(1'b0, 1'b1, 1'b1, 1'b0);
        e = mk(0, 12, 0, 0, 1'b0);
        total++;
        if (obs !== e) begin bad++; $display("FAIL button_pm_toggle: got %h want %h", obs, e); end
    endtask

    task automatic test_ignore_and_rst();
        logic [22:0] e;
        repeat (12) drive(1'b0, 1'b1, 1'b1, 1'b0);
        repeat (59) drive(1'b0, 1'b1, 1'b0, 1'b1);
        for (int i = 1; i <= 59 * TICK_DIV + TICK_DIV - 1; i++) begin
            drive(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            e = exp_vec();
            total++;
            if (obs !== e) begin bad++; $display("FAIL run_buttons_ignored c%0d: got %h want %h", i, obs, e); end
        end
        e = mk(1, 12, 59, 59, 1'b0);
        total++;
        if (obs !== e) begin bad++; $display("FAIL pre_carry_125959: got %h want %h", obs, e); end
        drive(1'b1, 1'b0, 1'b1, 1'b1);
        e = mk(0, 12, 0, 0, 1'b0);
        total++;
        if (obs !== e) begin bad++; $display("FAIL rst_mid_carry: got %h want %h", obs, e); end
        for (int i = 1; i <= TICK_DIV; i++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b0);
            e = (i < TICK_DIV) ? mk(0, 12, 0, 0, 1'b0) : mk(0, 12, 0, 1, 1'b1);
            total++;
            if (obs !== e) begin bad++; $display("FAIL post_reset_tick c%0d: got %h want %h", i, obs, e); end
        end
    endtask

    task automatic test_random();
        logic [22:0] e;
        logic        sm;
        sm = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 39) == 0) sm = ~sm;
            drive(1'($urandom_range(0, 299) == 0), sm,
                  1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 2) == 0));
            e = exp_vec();
            total++;
            if (obs !== e) begin bad++; $display("FAIL random c%0d: got %h want %h", i, obs, e); end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_first_second();
        test_set_rollover();
        test_noon_to_one();
        test_same_cycle();
        test_ignore_and_rst();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/time_cnt_12.md
TIME_CNT_12 -- requirements
Module: time_cnt_12

Interface
REQ-001 SHALL have parameter TICK_DIV, default 50_000_000, giving clk cycles per second (minimum 2).
REQ-002 SHALL have port clk, input, 1 bit: single system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port set_mode, input, 1 bit: 1 = time-set mode, 0 = run mode.
REQ-005 SHALL have port btn_hour, input, 1 bit: debounced single-cycle hour-advance pulse.
REQ-006 SHALL have port btn_min, input, 1 bit: debounced single-cycle minute-advance pulse.
REQ-007 SHALL have port sec_ones, output, 4 bits: seconds ones digit, BCD 0-9.
REQ-008 SHALL have port sec_tens, output, 4 bits: seconds tens digit, BCD 0-5.
REQ-009 SHALL have port min_ones, output, 4 bits: minutes ones digit, BCD 0-9.
REQ-010 SHALL have port min_tens, output, 4 bits: minutes tens digit, BCD 0-5.
REQ-011 SHALL have port hour_bin, output, 4 bits: hour in binary 1-12, consumed directly by the 12-hour segment decoder.
REQ-012 SHALL have port hour_tens, output, 1 bit: 1 when hour_bin >= 10.
REQ-013 SHALL have port sec_pulse, output, 1 bit: one-cycle pulse on each second advance.

Function
REQ-014 Divider SHALL count 0..TICK_DIV-1 in run mode; the internal tick SHALL assert in the cycle the count equals TICK_DIV-1, and the count SHALL wrap to 0.
REQ-015 On a tick, time SHALL advance one second; all outputs SHALL be registered, reflecting the new value one cycle after the tick cycle.
REQ-016 sec_pulse SHALL be high for exactly the cycle in which the new seconds value first appears.
REQ-017 Seconds 59 -> 00 SHALL carry into minutes; minutes 59 -> 00 SHALL carry into hours, all in the same update.
REQ-018 Hour SHALL advance 1..11 -> +1, and 12 -> 1; never 0 or above 12.
REQ-019 Hour transition 11 -> 12 SHALL toggle pm (when compiled in); 12 -> 1 SHALL NOT toggle pm.
REQ-020 BCD digits SHALL never hold values outside their ranges; ones 9 -> 0 SHALL increment the tens digit.
REQ-021 While set_mode=1, divider and seconds SHALL be held at 0, sec_pulse SHALL stay 0, and no tick SHALL occur.
REQ-022 In set mode, btn_hour SHALL advance the hour exactly per REQ-018/REQ-019.
REQ-023 In set mode, btn_min SHALL advance minutes 59 -> 00 with no carry into hours.
REQ-024 When btn_hour and btn_min are in the same cycle, both SHALL apply in that cycle.
REQ-025 Buttons SHALL be ignored while set_mode=0.
REQ-026 On set_mode 1 -> 0, the divider SHALL restart from 0; the first tick SHALL come TICK_DIV cycles later.

Reset
REQ-027 rst=1 at a clock edge SHALL force 12:00:00: hour_bin=12, hour_tens=1, min/sec digits=0, sec_pulse=0, divider=0, pm=0; rst SHALL override set_mode and buttons, including mid-carry.
REQ-028 After rst deasserts in run mode, the first tick SHALL occur TICK_DIV cycles later.

Configuration
REQ-029 With macro TIME_CNT_PM_FLAG_EN defined, output port pm (1 bit, 1 = PM) SHALL exist and behave per REQ-019/REQ-027.
REQ-030 Without TIME_CNT_PM_FLAG_EN, port pm and its register SHALL be absent; all other behaviour SHALL be unchanged.

Verification (TICK_DIV=4, TIME_CNT_PM_FLAG_EN defined)
REQ-031 Reset, then run 4 cycles -> 12:00:01, sec_pulse high exactly one cycle, pm=0.
REQ-032 Set mode: 11 x btn_hour and 59 x btn_min, then run 60 ticks -> 11:59:59 -> 12:00:00 with pm=1 and hour_tens=1.
REQ-033 From 12:59:59, one tick -> 01:00:00, hour_bin=1, hour_tens=0, pm unchanged.
REQ-034 Set mode at 10:59 with btn_hour and btn_min in the same cycle -> 11:00, hour unchanged by the minute wrap.
REQ-035 Run mode with btn_hour/btn_min pulses -> no change; rst asserted at 12:59:59 on a tick cycle -> 12:00:00, pm=0.
